matrix_stream_feeder: RTL

Host-side stream source/sink for the matrix compute core. It holds a 2×K operand A and a K×2 operand B, loaded through a simple write port. On `start` it transmits A, then B, as AXI-Stream masters into the compute core's A/B slave ports. It then accepts the 2×2 result C from the core's master port into a result buffer that the host can read back.

---
 rtl/matrix_stream_feeder.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/matrix_stream_feeder.sv
// Operand buffers for a 2xK by Kx2 product, streamed to the compute core as A then B,
// followed by capture of the four-beat C result into a host-readable buffer.
module matrix_stream_feeder #(
    parameter int DATA_W = 32,
    parameter int K_MAX  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [$clog2(K_MAX):0]        cfg_k,
    input  logic                          start,
    output logic                          busy,
    output logic                          done,
    output logic                          err,
    input  logic                          wr_en,
    input  logic                          wr_sel,
    input  logic [$clog2(2*K_MAX)-1:0]    wr_addr,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic [1:0]                    rd_addr,
    output logic [DATA_W-1:0]             rd_data,
    output logic [DATA_W-1:0]             m_axis_a_tdata,
    output logic                          m_axis_a_tvalid,
    input  logic                          m_axis_a_tready,
    output logic                          m_axis_a_tlast,
    output logic [DATA_W-1:0]             m_axis_b_tdata,
    output logic                          m_axis_b_tvalid,
    input  logic                          m_axis_b_tready,
    output logic                          m_axis_b_tlast,
    input  logic [DATA_W-1:0]             s_axis_c_tdata,
    input  logic                          s_axis_c_tvalid,
    output logic                          s_axis_c_tready,
    input  logic                          s_axis_c_tlast
);

    // state  | meaning
    // IDLE   | waiting for start; operand writes accepted
    // SEND_A | streaming A row-major, 2K beats
    // SEND_B | streaming B row-major, 2K beats
    // RECV_C | accepting four result beats
    // DONE   | one-cycle completion pulse

    localparam int KW = $clog2(K_MAX) + 1;
    localparam int AW = $clog2(2 * K_MAX);
    localparam int NBUF = 2 * K_MAX;
    localparam logic [KW-1:0] K_MAX_V = KW'(K_MAX);

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        RECV_C,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [KW-1:0]     k_q;
    logic [KW-1:0]     row_q;
    logic [KW-1:0]     col_q;
    logic [1:0]        c_cnt_q;
    logic              err_q;

    logic [DATA_W-1:0] buf_a [NBUF];
    logic [DATA_W-1:0] buf_b [NBUF];
    logic [DATA_W-1:0] result [4];

    logic              cfg_ok;
    logic              a_hs, b_hs, c_hs;
    logic              a_last, b_last, c_end;
    logic [AW-1:0]     a_addr, b_addr;
    logic              wr_ok;

    assign cfg_ok = (cfg_k != '0) && (cfg_k <= K_MAX_V);
    assign wr_ok  = wr_en && (state_q == IDLE) && (int'(wr_addr) < NBUF);

    // Row/column counters form the buffer address directly, so no divide is needed.
    assign a_addr = AW'(int'(row_q) * K_MAX + int'(col_q));
    assign b_addr = AW'(int'(row_q) * 2 + int'(col_q));

    assign a_last = (row_q == KW'(1)) && (col_q == k_q - 1'b1);
    assign b_last = (row_q == k_q - 1'b1) && (col_q == KW'(1));

    assign m_axis_a_tvalid = (state_q == SEND_A);
    assign m_axis_a_tdata  = m_axis_a_tvalid ? buf_a[a_addr] : '0;
    assign m_axis_a_tlast  = m_axis_a_tvalid && a_last;

    assign m_axis_b_tvalid = (state_q == SEND_B);
    assign m_axis_b_tdata  = m_axis_b_tvalid ? buf_b[b_addr] : '0;
    assign m_axis_b_tlast  = m_axis_b_tvalid && b_last;

    assign s_axis_c_tready = (state_q == RECV_C);

    assign a_hs  = m_axis_a_tvalid && m_axis_a_tready;
    assign b_hs  = m_axis_b_tvalid && m_axis_b_tready;
    assign c_hs  = s_axis_c_tready && s_axis_c_tvalid;
    assign c_end = s_axis_c_tlast || (c_cnt_q == 2'd3);

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign err     = err_q;
    assign rd_data = result[rd_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start && cfg_ok) begin
                    state_d = SEND_A;
                end
            end
            SEND_A: begin
                if (a_hs && a_last) begin
                    state_d = SEND_B;
                end
            end
            SEND_B: begin
                if (b_hs && b_last) begin
                    state_d = RECV_C;
                end
            end
            RECV_C: begin
                if (c_hs && c_end) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_q     <= '0;
            row_q   <= '0;
            col_q   <= '0;
            c_cnt_q <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (cfg_ok) begin
                            k_q     <= cfg_k;
                            row_q   <= '0;
                            col_q   <= '0;
                            c_cnt_q <= '0;
                            err_q   <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                SEND_A: begin
                    if (a_hs) begin
                        if (col_q == k_q - 1'b1) begin
                            col_q <= '0;
                            row_q <= a_last ? '0 : row_q + 1'b1;
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                SEND_B: begin
                    if (b_hs) begin
                        if (col_q == KW'(1)) begin
                            col_q <= '0;
                            row_q <= b_last ? '0 : row_q + 1'b1;
                        end else begin
                            col_q <= KW'(1);
                        end
                    end
                end
                RECV_C: begin
                    if (c_hs) begin
                        c_cnt_q <= c_cnt_q + 2'd1;
                        // Short frame (early tlast) and overlong frame (no tlast on beat 3) both flag.
                        if (s_axis_c_tlast != (c_cnt_q == 2'd3)) begin
                            err_q <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NBUF; i++) begin
                buf_a[i] <= '0;
                buf_b[i] <= '0;
            end
        end else if (wr_ok) begin
            if (wr_sel) begin
                buf_b[wr_addr] <= wr_data;
            end else begin
                buf_a[wr_addr] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                result[i] <= '0;
            end
        end else if ((state_q == RECV_C) && c_hs) begin
            result[c_cnt_q] <= s_axis_c_tdata;
        end
    end

endmodule
